// File: rtl/piso_serializer8_if.sv
// Word-load / serial-out bundle for piso_serializer8.
// master = word producer and bit consumer, slave = serializer.
interface piso_serializer8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  dout,
        input  dout_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output dout,
        output dout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serializer8.sv
// Parallel-in/serial-out word serializer with zero-gap streaming.
// Define PISO_PARITY_EN to append an even-parity bit to every word.
module piso_serializer8 #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    piso_serializer8_if.slave   bus
);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [FRAME-1:0] sreg;
    logic [FRAME-1:0] frame_w;
    logic [FRAME-1:0] sreg_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             last;
    logic             take;

    assign last = (state == SHIFT) && (bit_cnt == CW'(FRAME - 1));
    assign take = bus.load_valid && bus.load_ready;

    // Parity sits at the far end of the frame so it leaves last.
    always_comb begin
        frame_w = '0;
`ifdef PISO_PARITY_EN
        if (MSB_FIRST)
            frame_w = {bus.data_in, ^bus.data_in};
        else
            frame_w = {^bus.data_in, bus.data_in};
`else
        frame_w = bus.data_in;
`endif
    end

    always_comb begin
        sreg_nxt = '0;
        if (MSB_FIRST)
            sreg_nxt = {sreg[FRAME-2:0], 1'b0};
        else
            sreg_nxt = {1'b0, sreg[FRAME-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (take) begin
            state   <= SHIFT;
            sreg    <= frame_w;
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            if (last) begin
                state   <= IDLE;
                sreg    <= '0;
                bit_cnt <= '0;
            end else begin
                sreg    <= sreg_nxt;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    assign bus.load_ready = (state == IDLE) || last;
    assign bus.busy       = (state == SHIFT);
    assign bus.dout_valid = (state == SHIFT);
    assign bus.done       = last;
    assign bus.dout       = (state == SHIFT) &&
                            (MSB_FIRST ? sreg[FRAME-1] : sreg[0]);
endmodule

// File: tb/tb_piso_serializer8.sv
// Self-checking bench: MSB-first and LSB-first serializers side by side,
// scoreboard per instance plus a chained SIPO model.
module tb_piso_serializer8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic clk;
    logic rst_n;

    piso_serializer8_if #(.WIDTH(8)) m0();
    piso_serializer8_if #(.WIDTH(8)) m1();

    piso_serializer8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk),
        .reset(rst_n),
        .bus(m0.slave)
    );

    piso_serializer8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk),
        .reset(rst_n),
        .bus(m1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int run = 0;
    int max_run = 0;
    int done_times[$];
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [FRAME-1:0] sipo0 = '0;
    logic [FRAME-1:0] sipo1 = '0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] w, input bit msb,
                                  input int i);
        if (i >= 8)
            return ^w;
        return msb ? w[7-i] : w[i];
    endfunction

    always @(posedge clk) cyc++;

    // Expected frame bits go in when a word is accepted.
    always @(posedge clk) begin
        if (rst_n && m0.load_valid && m0.load_ready)
            for (int i = 0; i < FRAME; i++)
                q0.push_back({fbit(m0.data_in, 1'b1, i), i == FRAME - 1});
        if (rst_n && m1.load_valid && m1.load_ready)
            for (int i = 0; i < FRAME; i++)
                q1.push_back({fbit(m1.data_in, 1'b0, i), i == FRAME - 1});
    end

    always @(posedge clk) begin
        if (m0.dout_valid)
            sipo0 <= {sipo0[FRAME-2:0], m0.dout};
        if (m1.dout_valid)
            sipo1 <= {sipo1[FRAME-2:0], m1.dout};
    end

    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n) begin
            if (m0.dout_valid) begin
                run++;
                if (run > max_run)
                    max_run = run;
                if (m0.done)
                    done_times.push_back(cyc);
                if (q0.size() == 0) begin
                    chk("extra_bit0", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("dout0", m0.dout, e[1]);
                    chk("done0", m0.done, e[0]);
                end
            end else begin
                run = 0;
                chk("idle_done0", m0.done, 0);
            end
            if (m1.dout_valid) begin
                if (q1.size() == 0) begin
                    chk("extra_bit1", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("dout1", m1.dout, e[1]);
                    chk("done1", m1.done, e[0]);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        m0.load_valid = v;
        m1.load_valid = v;
        m0.data_in = d;
        m1.data_in = d;
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [7:0] w);
        int n = 0;
        drive(1'b1, w);
        while (!m0.load_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40)
            chk("send_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m0.busy || m1.busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60)
            chk("idle_timeout", 1, 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[1] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[2] = '{8'h01, 8'h01, 8'h80};
        vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[4] = '{8'h96, 8'h96, 8'h69};
        vecs[5] = '{8'hC1, 8'hC1, 8'h83};
        vecs[6] = '{8'h07, 8'h07, 8'hE0};
        vecs[7] = '{8'h03, 8'h03, 8'hC0};

        rst_n = 1'b0;
        drive(1'b1, 8'hFF);
        repeat (2) begin
            @(negedge clk);
            chk("rst_dout", m0.dout, 0);
            chk("rst_dv", m0.dout_valid, 0);
            chk("rst_busy", m0.busy, 0);
            chk("rst_done", m0.done, 0);
            chk("rst_ready", m0.load_ready, 1);
            chk("rst_busy1", m1.busy, 0);
        end
        drive(1'b0, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            send(vecs[k].data);
            drive(1'b0, 8'h00);
            wait_idle();
            chk("sipo0", sipo0[FRAME-1 -: 8], vecs[k].exp0);
            chk("sipo1", sipo1[FRAME-1 -: 8], vecs[k].exp1);
        end

        // Back-to-back stream with valid held high.
        done_times.delete();
        max_run = 0;
        send(8'hA5);
        send(8'h3C);
        drive(1'b0, 8'h00);
        wait_idle();
        chk("b2b_ndone", done_times.size(), 2);
        if (done_times.size() == 2)
            chk("b2b_gap", done_times[1] - done_times[0], FRAME);
        chk("b2b_run", max_run, 2 * FRAME);
        chk("b2b_sipo", sipo0[FRAME-1 -: 8], 8'h3C);

        // Offer while busy must be ignored.
        send(8'hA5);
        drive(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        drive(1'b1, 8'hFF);
        chk("busy_ready_a", m0.load_ready, 0);
        @(negedge clk);
        chk("busy_ready_b", m0.load_ready, 0);
        drive(1'b0, 8'h00);
        wait_idle();
        chk("ignore_sipo", sipo0[FRAME-1 -: 8], 8'hA5);

        // Async reset mid-word.
        send(8'hF0);
        drive(1'b0, 8'h00);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dout0", m0.dout, 0);
        chk("abort_dout1", m1.dout, 0);
        chk("abort_dv", m0.dout_valid, 0);
        chk("abort_busy", m0.busy, 0);
        chk("abort_done", m0.done, 0);
        chk("abort_ready", m0.load_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_busy", m0.busy, 0);
        chk("post_ready", m0.load_ready, 1);
        send(8'h0F);
        drive(1'b0, 8'h00);
        wait_idle();
        chk("post_sipo0", sipo0[FRAME-1 -: 8], 8'h0F);
        chk("post_sipo1", sipo1[FRAME-1 -: 8], 8'hF0);

        repeat (2) @(negedge clk);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
